// File: rtl/idli_fetch_ctrl_m.sv
// Fetch sequencer: drives the SQI read transaction, streams instruction nibbles
// to the decoder, collects trailing 16b immediates, and tracks the word PC.
module idli_fetch_ctrl_m #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter logic [7:0]  READ_CMD      = 8'h03,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic        i_fch_gck,
  input  logic        i_fch_rst_n,
  output logic        o_fch_sqi_cs_n,
  output logic        o_fch_sqi_sck_en,
  output logic        o_fch_sqi_oe,
  output logic [3:0]  o_fch_sqi_data,
  input  logic [3:0]  i_fch_sqi_data,
  input  logic        i_fch_stall,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  input  logic        i_fch_imm_req,
  output logic [3:0]  o_fch_enc,
  output logic        o_fch_enc_vld,
  output logic [15:0] o_fch_imm,
  output logic        o_fch_imm_vld,
  output logic [15:0] o_fch_pc
);

  // The address phase is six nibbles long, so the shared counter needs at least 3 bits.
  localparam int unsigned CNT_W = (DUMMY_NIBBLES > 8) ? $clog2(DUMMY_NIBBLES) : 3;

  localparam logic [CNT_W-1:0] CNT_1      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_3      = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_5      = CNT_W'(5);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_NIBBLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    INSTR = 3'd4,
    IMM   = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      pc_q;
  logic [11:0]      imm_sr_q;
  logic [15:0]      imm_q;
  logic             imm_vld_q;
  logic             imm_pend_q;

  logic [23:0]      byte_addr;
  logic [2:0]       nib_idx;
  logic             pc_wrap;
  logic             hold;

  assign byte_addr = {7'b0, pc_q, 1'b0};
  assign nib_idx   = cnt_q[2:0];
  assign pc_wrap   = (pc_q == 16'hFFFF);
  assign hold      = i_fch_stall && (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge i_fch_gck) begin
    if (!i_fch_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      imm_sr_q   <= '0;
      imm_q      <= '0;
      imm_vld_q  <= 1'b0;
      imm_pend_q <= 1'b0;
    end else begin
      // The valid pulse lasts one cycle even if the backend stalls.
      imm_vld_q <= 1'b0;
      if (i_fch_redirect) begin
        pc_q       <= i_fch_redirect_pc;
        state_q    <= IDLE;
        cnt_q      <= '0;
        imm_pend_q <= 1'b0;
      end else if (!hold) begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= '0;
          end
          CMD: begin
            if (cnt_q == CNT_1) begin
              state_q <= ADDR;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_1;
            end
          end
          ADDR: begin
            if (cnt_q == CNT_5) begin
              state_q <= DUMMY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_1;
            end
          end
          DUMMY: begin
            if (cnt_q == DUMMY_LAST) begin
              // An immediate interrupted by a PC wrap resumes right after re-addressing.
              state_q    <= imm_pend_q ? IMM : INSTR;
              imm_pend_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_1;
            end
          end
          INSTR: begin
            if (cnt_q == CNT_3) begin
              cnt_q <= '0;
              pc_q  <= pc_q + 16'd1;
              if (pc_wrap) begin
                state_q    <= IDLE;
                imm_pend_q <= i_fch_imm_req;
              end else if (i_fch_imm_req) begin
                state_q <= IMM;
              end
            end else begin
              cnt_q <= cnt_q + CNT_1;
            end
          end
          IMM: begin
            imm_sr_q <= {imm_sr_q[7:0], i_fch_sqi_data};
            if (cnt_q == CNT_3) begin
              cnt_q     <= '0;
              pc_q      <= pc_q + 16'd1;
              imm_q     <= {imm_sr_q, i_fch_sqi_data};
              imm_vld_q <= 1'b1;
              state_q   <= pc_wrap ? IDLE : INSTR;
            end else begin
              cnt_q <= cnt_q + CNT_1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_fch_sqi_cs_n   = 1'b1;
    o_fch_sqi_sck_en = 1'b0;
    o_fch_sqi_oe     = 1'b0;
    o_fch_sqi_data   = 4'h0;
    case (state_q)
      CMD: begin
        o_fch_sqi_cs_n   = 1'b0;
        o_fch_sqi_sck_en = !i_fch_stall;
        o_fch_sqi_oe     = 1'b1;
        o_fch_sqi_data   = nib_idx[0] ? READ_CMD[3:0] : READ_CMD[7:4];
      end
      ADDR: begin
        o_fch_sqi_cs_n   = 1'b0;
        o_fch_sqi_sck_en = !i_fch_stall;
        o_fch_sqi_oe     = 1'b1;
        case (nib_idx)
          3'd0:    o_fch_sqi_data = byte_addr[23:20];
          3'd1:    o_fch_sqi_data = byte_addr[19:16];
          3'd2:    o_fch_sqi_data = byte_addr[15:12];
          3'd3:    o_fch_sqi_data = byte_addr[11:8];
          3'd4:    o_fch_sqi_data = byte_addr[7:4];
          default: o_fch_sqi_data = byte_addr[3:0];
        endcase
      end
      DUMMY, INSTR, IMM: begin
        o_fch_sqi_cs_n   = 1'b0;
        o_fch_sqi_sck_en = !i_fch_stall;
      end
      default: ;
    endcase
  end

  assign o_fch_enc     = i_fch_sqi_data;
  assign o_fch_enc_vld = (state_q == INSTR) && !i_fch_stall;
  assign o_fch_imm     = imm_q;
  assign o_fch_imm_vld = imm_vld_q;
  assign o_fch_pc      = pc_q;

endmodule

// File: tb/tb_idli_fetch_ctrl_m.sv
// Directed bench for idli_fetch_ctrl_m: one default instance plus one with
// RESET_PC=16'hFFFF for the PC-wrap boundary.
module tb_idli_fetch_ctrl_m;

  logic        clk;
  logic        rst_n;
  logic        rst_w_n;
  logic [3:0]  sqi_in;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imm_req;
  logic        use_w;

  logic        d_cs_n, d_sck_en, d_oe, d_enc_vld, d_imm_vld;
  logic [3:0]  d_sqi_out, d_enc;
  logic [15:0] d_imm, d_pc;
  logic        w_cs_n, w_sck_en, w_oe, w_enc_vld, w_imm_vld;
  logic [3:0]  w_sqi_out, w_enc;
  logic [15:0] w_imm, w_pc;

  logic        m_cs_n, m_sck_en, m_oe, m_enc_vld, m_imm_vld;
  logic [3:0]  m_sqi_out, m_enc;
  logic [15:0] m_imm, m_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  idli_fetch_ctrl_m dut (
    .i_fch_gck         (clk),
    .i_fch_rst_n       (rst_n),
    .o_fch_sqi_cs_n    (d_cs_n),
    .o_fch_sqi_sck_en  (d_sck_en),
    .o_fch_sqi_oe      (d_oe),
    .o_fch_sqi_data    (d_sqi_out),
    .i_fch_sqi_data    (sqi_in),
    .i_fch_stall       (stall),
    .i_fch_redirect    (redirect),
    .i_fch_redirect_pc (redirect_pc),
    .i_fch_imm_req     (imm_req),
    .o_fch_enc         (d_enc),
    .o_fch_enc_vld     (d_enc_vld),
    .o_fch_imm         (d_imm),
    .o_fch_imm_vld     (d_imm_vld),
    .o_fch_pc          (d_pc)
  );

  idli_fetch_ctrl_m #(.RESET_PC(16'hFFFF)) dut_w (
    .i_fch_gck         (clk),
    .i_fch_rst_n       (rst_w_n),
    .o_fch_sqi_cs_n    (w_cs_n),
    .o_fch_sqi_sck_en  (w_sck_en),
    .o_fch_sqi_oe      (w_oe),
    .o_fch_sqi_data    (w_sqi_out),
    .i_fch_sqi_data    (sqi_in),
    .i_fch_stall       (stall),
    .i_fch_redirect    (redirect),
    .i_fch_redirect_pc (redirect_pc),
    .i_fch_imm_req     (imm_req),
    .o_fch_enc         (w_enc),
    .o_fch_enc_vld     (w_enc_vld),
    .o_fch_imm         (w_imm),
    .o_fch_imm_vld     (w_imm_vld),
    .o_fch_pc          (w_pc)
  );

  assign m_cs_n    = use_w ? w_cs_n    : d_cs_n;
  assign m_sck_en  = use_w ? w_sck_en  : d_sck_en;
  assign m_oe      = use_w ? w_oe      : d_oe;
  assign m_sqi_out = use_w ? w_sqi_out : d_sqi_out;
  assign m_enc     = use_w ? w_enc     : d_enc;
  assign m_enc_vld = use_w ? w_enc_vld : d_enc_vld;
  assign m_imm     = use_w ? w_imm     : d_imm;
  assign m_imm_vld = use_w ? w_imm_vld : d_imm_vld;
  assign m_pc      = use_w ? w_pc      : d_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    imm_req = 1'b0;
  endtask

  // Current cycle must be IDLE; walks CMD, ADDR and DUMMY and leaves the next tick in INSTR/IMM.
  task automatic hdr(input logic [23:0] addr);
    logic [7:0] cmd;
    cmd = 8'h03;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("cmd_cs_n", m_cs_n, 0);
      check("cmd_oe", m_oe, 1);
      check("cmd_sck_en", m_sck_en, 1);
      check("cmd_nib", m_sqi_out, cmd[7-4*i -: 4]);
    end
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      check("addr_oe", m_oe, 1);
      check("addr_nib", m_sqi_out, addr[23-4*i -: 4]);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("dummy_cs_n", m_cs_n, 0);
      check("dummy_oe", m_oe, 0);
      check("dummy_sck_en", m_sck_en, 1);
      check("dummy_enc_vld", m_enc_vld, 0);
    end
  endtask

  // Streams one instruction word; req_mask[i] drives imm_req on nibble i.
  task automatic word(input logic [15:0] w, input logic [3:0] req_mask, input logic [15:0] exp_pc);
    for (int i = 0; i < 4; i++) begin
      tick();
      sqi_in  = w[15-4*i -: 4];
      imm_req = req_mask[i];
      #1;
      check("enc_vld", m_enc_vld, 1);
      check("enc", m_enc, w[15-4*i -: 4]);
      check("pc", m_pc, exp_pc);
    end
  endtask

  task automatic imm_nibbles(input logic [15:0] v, input logic [15:0] exp_pc);
    for (int i = 0; i < 4; i++) begin
      tick();
      sqi_in = v[15-4*i -: 4];
      #1;
      check("imm_enc_vld", m_enc_vld, 0);
      check("imm_sck_en", m_sck_en, 1);
      check("imm_vld_early", m_imm_vld, 0);
      check("imm_pc", m_pc, exp_pc);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_w_n = 1'b0; use_w = 1'b0;
    sqi_in = 4'h0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; imm_req = 1'b0;

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_cs_n", m_cs_n, 1);
    check("rst_sck_en", m_sck_en, 0);
    check("rst_oe", m_oe, 0);
    check("rst_enc_vld", m_enc_vld, 0);
    check("rst_imm_vld", m_imm_vld, 0);
    check("rst_pc", m_pc, 16'h0000);

    // Release: this cycle is IDLE, first enc_vld 11 cycles later
    rst_n = 1'b1;
    #1;
    check("idle_cs_n", m_cs_n, 1);
    hdr(24'h000000);
    word(16'h1234, 4'b0000, 16'h0000);
    word(16'hC56A, 4'b0000, 16'h0001);

    // Trailing immediate BEEF after word 8FFF
    word(16'h8FFF, 4'b1000, 16'h0002);
    imm_nibbles(16'hBEEF, 16'h0003);

    // Next word 9ABC: imm pulse on nibble 0, then 3-cycle stall on nibble 2
    tick(); sqi_in = 4'h9; #1;
    check("imm_vld_pulse", m_imm_vld, 1);
    check("imm_value", m_imm, 16'hBEEF);
    check("pc_after_imm", m_pc, 16'h0004);
    check("enc_vld_after_imm", m_enc_vld, 1);
    tick(); sqi_in = 4'hA; #1;
    check("imm_vld_drop", m_imm_vld, 0);
    check("imm_hold", m_imm, 16'hBEEF);
    tick(); sqi_in = 4'hB; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      check("stall_sck_en", m_sck_en, 0);
      check("stall_enc_vld", m_enc_vld, 0);
      check("stall_pc", m_pc, 16'h0004);
    end
    tick(); stall = 1'b0; #1;
    check("unstall_enc_vld", m_enc_vld, 1);
    check("unstall_enc", m_enc, 4'hB);
    check("unstall_pc", m_pc, 16'h0004);
    tick(); sqi_in = 4'hC; #1;
    check("nib3_pc", m_pc, 16'h0004);
    check("nib3_enc_vld", m_enc_vld, 1);

    // Redirect to 0100 at nibble 1 concurrent with stall
    tick(); sqi_in = 4'h1; #1;
    check("w1357_pc", m_pc, 16'h0005);
    tick(); sqi_in = 4'h3; stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100; #1;
    check("redir_stall_enc_vld", m_enc_vld, 0);
    tick(); stall = 1'b0; redirect = 1'b0; #1;
    check("redir_cs_n", m_cs_n, 1);
    check("redir_sck_en", m_sck_en, 0);
    check("redir_pc", m_pc, 16'h0100);
    hdr(24'h000200);
    // imm_req on non-final nibbles must be ignored
    word(16'h2468, 4'b0111, 16'h0100);
    word(16'h0F0F, 4'b0000, 16'h0101);

    // Wrap on INSTR->IMM: immediate restarts at pc 0 after re-addressing
    tick(); redirect = 1'b1; redirect_pc = 16'hFFFF; #1;
    tick(); redirect = 1'b0; #1;
    check("wrapimm_idle_cs_n", m_cs_n, 1);
    check("wrapimm_pc", m_pc, 16'hFFFF);
    hdr(24'h01FFFE);
    word(16'hA001, 4'b1000, 16'hFFFF);
    tick(); #1;
    check("wrap_idle_cs_n", m_cs_n, 1);
    check("wrap_idle_sck_en", m_sck_en, 0);
    check("wrap_pc0", m_pc, 16'h0000);
    hdr(24'h000000);
    imm_nibbles(16'h1234, 16'h0000);
    tick(); sqi_in = 4'h0; #1;
    check("wrap_imm_vld", m_imm_vld, 1);
    check("wrap_imm", m_imm, 16'h1234);
    check("wrap_imm_pc", m_pc, 16'h0001);
    check("wrap_instr_enc_vld", m_enc_vld, 1);

    // Redirect to 0042, stall in IDLE has no effect, reset at ADDR nibble 3
    tick(); redirect = 1'b1; redirect_pc = 16'h0042; #1;
    tick(); redirect = 1'b0; stall = 1'b1; #1;
    check("idle_stall_cs_n", m_cs_n, 1);
    check("idle_stall_pc", m_pc, 16'h0042);
    tick(); stall = 1'b0; #1;
    check("idle_stall_cmd0_cs_n", m_cs_n, 0);
    check("idle_stall_cmd0_nib", m_sqi_out, 4'h0);
    tick(); #1;
    check("cmd1_nib", m_sqi_out, 4'h3);
    tick(); #1;
    check("a0042_n0", m_sqi_out, 4'h0);
    tick(); #1;
    check("a0042_n1", m_sqi_out, 4'h0);
    tick(); #1;
    check("a0042_n2", m_sqi_out, 4'h0);
    tick(); rst_n = 1'b0; #1;
    check("a0042_n3_oe", m_oe, 1);
    tick(); rst_n = 1'b1; #1;
    check("midrst_cs_n", m_cs_n, 1);
    check("midrst_oe", m_oe, 0);
    check("midrst_sck_en", m_sck_en, 0);
    check("midrst_pc", m_pc, 16'h0000);
    hdr(24'h000000);
    word(16'h1234, 4'b0000, 16'h0000);

    // RESET_PC=FFFF instance: word at FFFF, wrap to IDLE, re-address byte 0
    tick(); use_w = 1'b1; rst_w_n = 1'b1; #1;
    check("w_idle_cs_n", m_cs_n, 1);
    check("w_reset_pc", m_pc, 16'hFFFF);
    hdr(24'h01FFFE);
    word(16'h4321, 4'b0000, 16'hFFFF);
    tick(); #1;
    check("w_wrap_cs_n", m_cs_n, 1);
    check("w_wrap_enc_vld", m_enc_vld, 0);
    check("w_wrap_pc", m_pc, 16'h0000);
    hdr(24'h000000);
    word(16'h5678, 4'b0000, 16'h0000);
    tick(); #1;
    check("w_resume_pc", m_pc, 16'h0001);
    check("w_resume_enc_vld", m_enc_vld, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
